// File: rtl/seven_segment_mux_counter.sv
// Multi-digit BCD seconds-style counter with programmable prescaler and a scanned seven-segment output.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seven_segment_mux_counter #(
  parameter int                    DIGITS          = 4,
  parameter int                    PRESCALE_W      = 24,
  parameter logic [PRESCALE_W-1:0] DEFAULT_COMPARE = 24'd10_000_000,
  parameter int                    SCAN_DIV        = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [PRESCALE_W-1:0] compare_in,
  input  logic                  update_compare,
  input  logic                  count_en,
  output logic [6:0]            seg_out,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  tick_o
);

  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [SCAN_W-1:0] LAST_SCAN = SCAN_W'(SCAN_DIV - 1);

  logic [PRESCALE_W-1:0] prescaler;
  logic [PRESCALE_W-1:0] compare_q;
  logic [3:0]            value     [DIGITS];
  logic [3:0]            value_inc [DIGITS];
  logic [SCAN_W-1:0]     scan_cnt;
  logic [IDX_W-1:0]      index;
  logic [IDX_W-1:0]      next_index;
  logic                  wrap;
  logic [6:0]            seg_next;

  function automatic logic [6:0] encode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111100;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1100111;
      default: return 7'b0000000;
    endcase
  endfunction

  // compare_q == 0 never wraps, which freezes the prescaler and the value.
  assign wrap = count_en && (compare_q != '0) &&
                (prescaler == compare_q - PRESCALE_W'(1));

  assign next_index = (index == LAST_IDX) ? '0 : index + IDX_W'(1);

  always_comb begin
    logic carry;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      value_inc[i] = value[i];
      if (carry) begin
        if (value[i] == 4'd9) begin
          value_inc[i] = 4'd0;
        end else begin
          value_inc[i] = value[i] + 4'd1;
          carry        = 1'b0;
        end
      end
    end
  end

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic blank;
`endif
    seg_next = encode(value[index]);
`ifdef LEADING_ZERO_BLANK_EN
    // Blank only when the scanned digit and everything above it is zero.
    blank = (index != '0);
    for (int i = 0; i < DIGITS; i++) begin
      if ((i >= int'(index)) && (value[i] != 4'd0)) blank = 1'b0;
    end
    if (blank) seg_next = 7'b0000000;
`endif
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      prescaler <= '0;
      compare_q <= DEFAULT_COMPARE;
      for (int i = 0; i < DIGITS; i++) value[i] <= 4'd0;
      scan_cnt  <= '0;
      index     <= '0;
      digit_sel <= DIGITS'(1);
      seg_out   <= 7'b0111111;
      tick_o    <= 1'b0;
    end else begin
      tick_o <= 1'b0;
      if (update_compare) begin
        compare_q <= compare_in;
        prescaler <= '0;
      end else if (count_en && (compare_q != '0)) begin
        if (wrap) begin
          prescaler <= '0;
          tick_o    <= 1'b1;
          value     <= value_inc;
        end else begin
          prescaler <= prescaler + PRESCALE_W'(1);
        end
      end

      if (scan_cnt == LAST_SCAN) begin
        scan_cnt <= '0;
        index    <= next_index;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end

      // Both display outputs come from the same index register so they move together.
      digit_sel <= DIGITS'(1) << index;
      seg_out   <= seg_next;
    end
  end

endmodule

// File: tb/tb_seven_segment_mux_counter.sv
// Self-checking bench: a 4-digit scanned instance and a 1-digit unscanned instance driven by shared stimulus.
module tb_seven_segment_mux_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        update_compare;
  logic        count_en;
  logic [23:0] compare_in;
  logic [6:0]  seg0, seg1;
  logic [3:0]  sel0;
  logic [0:0]  sel1;
  logic        tick0, tick1;

  int checks = 0;
  int errors = 0;
  int model  = 0;

  typedef struct {
    int n_ticks;
    int exp_val;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  seven_segment_mux_counter #(
    .DIGITS(4), .PRESCALE_W(24), .DEFAULT_COMPARE(24'd50), .SCAN_DIV(2)
  ) u0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .compare_in(compare_in),
    .update_compare(update_compare), .count_en(count_en),
    .seg_out(seg0), .digit_sel(sel0), .tick_o(tick0)
  );

  seven_segment_mux_counter #(
    .DIGITS(1), .PRESCALE_W(24), .DEFAULT_COMPARE(24'd50), .SCAN_DIV(1)
  ) u1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .compare_in(compare_in),
    .update_compare(update_compare), .count_en(count_en),
    .seg_out(seg1), .digit_sel(sel1), .tick_o(tick1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111100;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1100111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] exp_disp(input int val, input int idx);
    int p;
    p = 10 ** idx;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && (val / p) == 0) return 7'b0000000;
`endif
    return enc((val / p) % 10);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_compare(input int v);
    compare_in     = 24'(v);
    update_compare = 1'b1;
    step();
    update_compare = 1'b0;
  endtask

  task automatic run_ticks(input int n, input int cmp);
    int seen, gap, bad;
    seen = 0; gap = 0; bad = 0;
    count_en = 1'b1;
    for (int c = 0; c < n * cmp + 20 && seen < n; c++) begin
      step();
      gap++;
      if (tick0) begin
        if (gap != cmp) bad++;
        gap = 0;
        seen++;
      end
    end
    count_en = 1'b0;
    check("tick_count", 32'(seen), 32'(n));
    check("tick_period", 32'(bad), 32'd0);
  endtask

  task automatic read_display(input int val);
    logic [6:0] cap [4];
    int not_onehot;
    not_onehot = 0;
    for (int i = 0; i < 4; i++) cap[i] = 'x;
    for (int c = 0; c < 12; c++) begin
      step();
      if (c >= 2) begin
        case (sel0)
          4'b0001: cap[0] = seg0;
          4'b0010: cap[1] = seg0;
          4'b0100: cap[2] = seg0;
          4'b1000: cap[3] = seg0;
          default: not_onehot++;
        endcase
      end
    end
    check("sel_onehot", 32'(not_onehot), 32'd0);
    for (int i = 0; i < 4; i++) check($sformatf("disp_%0d_digit%0d", val, i), 32'(cap[i]), 32'(exp_disp(val, i)));
  endtask

  initial begin
    int n, ticks, seen, gap, idx;
    logic pend;

    vecs[0] = '{9, 9};
    vecs[1] = '{1, 10};
    vecs[2] = '{89, 99};
    vecs[3] = '{1, 100};
    vecs[4] = '{9899, 9999};
    vecs[5] = '{1, 0};
    vecs[6] = '{42, 42};

    rst = 1'b1; count_en = 1'b0; update_compare = 1'b0; compare_in = '0;
    @(negedge clk);
    repeat (3) step();
    check("rst_seg0", 32'(seg0), 32'(7'b0111111));
    check("rst_sel0", 32'(sel0), 32'(4'b0001));
    check("rst_tick0", 32'(tick0), 32'd0);
    check("rst_seg1", 32'(seg1), 32'(7'b0111111));

    // Scan order after release: digit 0 gets one extra cycle from the reset value, then 2 cycles each.
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      idx = ((k - 1) / 2) % 4;
      check($sformatf("scan_sel_k%0d", k), 32'(sel0), 32'(4'b0001 << idx));
      check($sformatf("scan_seg_k%0d", k), 32'(seg0), 32'(exp_disp(0, idx)));
    end

    // First tick with the default compare of 50.
    count_en = 1'b1;
    n = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      n++;
      if (tick0) break;
    end
    count_en = 1'b0;
    check("first_tick_cycle", 32'(n), 32'd50);
    model = 1;

    // Update on the wrap edge of compare=5 suppresses that tick; next tick 3 cycles later.
    load_compare(5);
    count_en = 1'b1;
    ticks = 0;
    repeat (4) begin
      step();
      if (tick0) ticks++;
    end
    compare_in = 24'd3; update_compare = 1'b1;
    step();
    update_compare = 1'b0;
    check("update_prio_no_tick", 32'(tick0), 32'd0);
    check("update_prio_early", 32'(ticks), 32'd0);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      n++;
      if (tick0) break;
    end
    count_en = 1'b0;
    check("update_next_tick", 32'(n), 32'd3);
    model = 2;
    read_display(2);

    // compare=0 freezes; compare_in changes without update are ignored.
    load_compare(0);
    count_en = 1'b1;
    compare_in = 24'd1;
    ticks = 0;
    repeat (30) begin
      step();
      if (tick0) ticks++;
    end
    count_en = 1'b0;
    check("compare0_no_ticks", 32'(ticks), 32'd0);
    read_display(2);

    // count_en low holds the prescaler mid-period.
    load_compare(4);
    count_en = 1'b1;
    step(); step();
    count_en = 1'b0;
    ticks = 0;
    repeat (10) begin
      step();
      if (tick0) ticks++;
    end
    count_en = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      n++;
      if (tick0) break;
    end
    count_en = 1'b0;
    check("hold_no_ticks", 32'(ticks), 32'd0);
    check("hold_resume", 32'(n), 32'd2);
    model = 3;

    // Single-digit instance walks the codes; seg_out lags tick_o by one cycle.
    load_compare(4);
    count_en = 1'b1;
    seen = 0; gap = 0; pend = 1'b0;
    for (int c = 0; c < 80 && (seen < 10 || pend); c++) begin
      step();
      gap++;
      if (pend) begin
        check($sformatf("walk_new_%0d", model % 10), 32'(seg1), 32'(enc(model % 10)));
        pend = 1'b0;
      end
      if (tick1) begin
        check("walk_period", 32'(gap), 32'd4);
        check($sformatf("walk_old_%0d", model % 10), 32'(seg1), 32'(enc(model % 10)));
        model++;
        pend = 1'b1;
        gap = 0;
        seen++;
      end
    end
    count_en = 1'b0;
    check("walk_ticks", 32'(seen), 32'd10);

    // Reset mid-count with a non-zero value clears everything.
    count_en = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    check("midrst_seg0", 32'(seg0), 32'(7'b0111111));
    check("midrst_sel0", 32'(sel0), 32'(4'b0001));
    check("midrst_tick0", 32'(tick0), 32'd0);
    check("midrst_seg1", 32'(seg1), 32'(7'b0111111));
    count_en = 1'b0;
    rst = 1'b0;
    read_display(0);

    // Decimal carry table at compare=2, cumulative.
    load_compare(2);
    for (int v = 0; v < 7; v++) begin
      run_ticks(vecs[v].n_ticks, 2);
      read_display(vecs[v].exp_val);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
